// File: rtl/restoring_signed_divider_if.sv
// Handshake and operand/result bundle for the signed divider.
// The master requests work; the slave is the divider itself.
interface restoring_signed_divider_if;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        overflow;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder,
    input  overflow, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder,
    output overflow, div_by_zero
  );
endinterface

// File: rtl/restoring_signed_divider.sv
// Radix-2 restoring divider: 64b / 32b signed, one quotient bit per cycle.
// Works on magnitudes and applies the signs when the results are registered.
module restoring_signed_divider (
  input  logic                       clk,
  input  logic                       reset,
  restoring_signed_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t      state;
  logic [31:0] rem_r;
  logic [63:0] quo_r;
  logic [31:0] dvs_mag;
  logic [5:0]  count;
  logic        sign_q;
  logic        sign_r;
  logic        dz;
  logic [31:0] dvd_lo;

  logic [63:0] dvd_abs;
  logic [31:0] dvs_abs;
  logic [32:0] rem_sh;
  logic        fits;
  logic [31:0] rem_next;
  logic        ovf;
  logic [31:0] q_out;
  logic [31:0] r_out;

  // Operand magnitudes, one restoring step, and sign-corrected results.
  always_comb begin
    dvd_abs  = bus.dividend[63] ? -bus.dividend : bus.dividend;
    dvs_abs  = bus.divisor[31] ? -bus.divisor : bus.divisor;
    rem_sh   = {rem_r, quo_r[63]};
    fits     = rem_sh >= {1'b0, dvs_mag};
    rem_next = fits ? 32'(rem_sh - {1'b0, dvs_mag})
                    : rem_sh[31:0];
    ovf      = sign_q ? (quo_r > 64'h0000_0000_8000_0000)
                      : (quo_r > 64'h0000_0000_7FFF_FFFF);
    q_out    = sign_q ? -quo_r[31:0] : quo_r[31:0];
    r_out    = sign_r ? -rem_r : rem_r;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rem_r           <= '0;
      quo_r           <= '0;
      dvs_mag         <= '0;
      count           <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      dz              <= 1'b0;
      dvd_lo          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.overflow    <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            sign_q   <= bus.dividend[63] ^ bus.divisor[31];
            sign_r   <= bus.dividend[63];
            dvd_lo   <= bus.dividend[31:0];
            dvs_mag  <= dvs_abs;
            quo_r    <= dvd_abs;
            rem_r    <= '0;
            count    <= '0;
            if (bus.divisor == 32'd0) begin
              dz    <= 1'b1;
              state <= FINISH;
            end else begin
              dz    <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= rem_next;
          quo_r <= {quo_r[62:0], fits};
          count <= count + 6'd1;
          if (count == 6'd63) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
          if (dz) begin
            bus.quotient    <= '0;
            bus.remainder   <= dvd_lo;
            bus.overflow    <= 1'b0;
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.quotient    <= q_out;
            bus.remainder   <= r_out;
            bus.overflow    <= ovf;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
